bandai_map_cfg_seq: RTL

- Host-side sequencer that brings the BANDAI2003 mapper out of lock and programs its four bank registers (C0h LAO, C1h RAMB, C2h ROMB0, C3h ROMB1) from one request.
- Unlock: issues the A5h address strobe, then captures and checks the 18-bit SO response.
- Programming: issues WEn-strobed writes, then optionally reads each register back.
- Sits between the system bus/boot logic and the mapper pins; DQ is split into o/oe/i, so the tristate stays at the top level.

---
 rtl/bandai_pkg.sv | 32 +++
 rtl/bandai_so_checker.sv | 34 +++
 rtl/bandai_map_cfg_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/bandai_pkg.sv
// Shared constants and enums for the BANDAI2003 mapper configuration sequencer.
package bandai_pkg;

  localparam logic [7:0] ADDR_NAK   = 8'hA5;
  localparam logic [7:0] ADDR_LAO   = 8'hC0;
  localparam logic [7:0] ADDR_RAMB  = 8'hC1;
  localparam logic [7:0] ADDR_ROMB0 = 8'hC2;
  localparam logic [7:0] ADDR_ROMB1 = 8'hC3;

  // {1'b0, 16'h28A0, 1'b0}; bit 0 is the first bit on SO.
  localparam logic [17:0] UNLOCK_SIG = 18'h05140;
  localparam int          UNLOCK_LEN = 18;

  typedef enum logic [1:0] {
    ERR_OK  = 2'b00,
    ERR_SIG = 2'b01,
    ERR_RB  = 2'b10
  } err_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_UNLOCK,
    S_SYNC,
    S_W_SETUP,
    S_W_STROBE,
    S_W_HOLD,
    S_R_READ,
    S_GAP,
    S_FIN
  } state_t;

endpackage

// File: rtl/bandai_so_checker.sv
// Serial checker for the mapper's SO unlock signature, one bit per enabled cycle.
module bandai_so_checker
  import bandai_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  input  logic so,
  output logic mismatch,
  output logic pass
);

  logic [17:0] sr;
  logic [4:0]  left;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      left <= '0;
    end else if (load) begin
      sr   <= UNLOCK_SIG;
      left <= 5'(UNLOCK_LEN - 1);
    end else if (en) begin
      sr <= {1'b0, sr[17:1]};
      if (left != 5'd0) left <= left - 5'd1;
    end
  end

  // The sequencer aborts on the first mismatch, so a match on the last bit means all matched.
  assign mismatch = en && (so != sr[0]);
  assign pass     = en && (so == sr[0]) && (left == 5'd0);

endmodule

// File: rtl/bandai_map_cfg_seq.sv
// Unlocks the BANDAI2003 mapper and programs its four bank registers from one request.
module bandai_map_cfg_seq #(
  parameter int SETUP_CYC  = 1,
  parameter int WE_LOW_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int VERIFY     = 1
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_banks,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic        unlocked,
  output logic [7:0]  m_addr,
  output logic        m_cen,
  output logic        m_wen,
  output logic        m_oen,
  output logic        m_ssn,
  input  logic        m_so,
  output logic [7:0]  m_dq_o,
  output logic        m_dq_oe,
  input  logic [7:0]  m_dq_i
);
  import bandai_pkg::*;

  state_t      state, nxt;
  logic [1:0]  idx, nxt_idx;
  logic [4:0]  cnt;
  logic [31:0] banks;
  err_t        err_q;
  logic        accept, leave, so_mismatch, so_pass, rb_fail;
  logic [31:0] wsrc;
  logic [7:0]  wbyte, rbyte, waddr;

  function automatic logic [4:0] dur(state_t s);
    case (s)
      S_SYNC:     dur = 5'(UNLOCK_LEN);
      S_W_SETUP:  dur = 5'(SETUP_CYC);
      S_W_STROBE: dur = 5'(WE_LOW_CYC);
      S_W_HOLD:   dur = 5'(HOLD_CYC);
      S_R_READ:   dur = 5'd2;
      default:    dur = 5'd1;
    endcase
  endfunction

  bandai_so_checker u_so (
    .clk      (CLK),
    .rst_n    (RSTn),
    .load     (state == S_UNLOCK),
    .en       (state == S_SYNC),
    .so       (m_so),
    .mismatch (so_mismatch),
    .pass     (so_pass)
  );

  assign accept  = req_valid && req_ready;
  assign leave   = (cnt == 5'd0);
  assign rbyte   = banks[{idx, 3'b000} +: 8];
  assign rb_fail = (state == S_R_READ) && leave && (m_dq_i != rbyte);
  // On the accept edge the request word is not in banks yet.
  assign wsrc    = accept ? req_banks : banks;
  assign wbyte   = wsrc[{nxt_idx, 3'b000} +: 8];
  assign waddr   = ADDR_LAO + {6'd0, nxt_idx};
  assign err     = err_q;

  always_comb begin
    nxt     = state;
    nxt_idx = idx;
    case (state)
      S_IDLE: if (accept) begin
        nxt     = unlocked ? S_W_SETUP : S_UNLOCK;
        nxt_idx = 2'd0;
      end
      S_UNLOCK:   nxt = S_SYNC;
      S_SYNC: begin
        if (so_mismatch)  nxt = S_FIN;
        else if (so_pass) nxt = S_W_SETUP;
      end
      S_W_SETUP:  if (leave) nxt = S_W_STROBE;
      S_W_STROBE: if (leave) nxt = S_W_HOLD;
      S_W_HOLD:   if (leave) nxt = (VERIFY != 0) ? S_R_READ : S_GAP;
      S_R_READ:   if (leave) nxt = rb_fail ? S_FIN : S_GAP;
      S_GAP: begin
        if (idx == 2'd3) nxt = S_FIN;
        else begin
          nxt     = S_W_SETUP;
          nxt_idx = idx + 2'd1;
        end
      end
      S_FIN:      nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end

  // Pin values are registered from the next state so each state's outputs appear on entry.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= S_IDLE;
      idx       <= 2'd0;
      cnt       <= 5'd0;
      banks     <= '0;
      err_q     <= ERR_OK;
      unlocked  <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      m_addr    <= 8'h00;
      m_cen     <= 1'b1;
      m_wen     <= 1'b1;
      m_oen     <= 1'b1;
      m_ssn     <= 1'b1;
      m_dq_oe   <= 1'b0;
      m_dq_o    <= 8'h00;
    end else begin
      state <= nxt;
      idx   <= nxt_idx;
      if (nxt != state)      cnt <= dur(nxt) - 5'd1;
      else if (cnt != 5'd0)  cnt <= cnt - 5'd1;

      if (accept) begin
        banks <= req_banks;
        err_q <= ERR_OK;
      end
      if (so_mismatch) err_q    <= ERR_SIG;
      if (so_pass)     unlocked <= 1'b1;
      if (rb_fail)     err_q    <= ERR_RB;

      req_ready <= (nxt == S_IDLE);
      busy      <= (nxt != S_IDLE);
      done      <= (nxt == S_FIN);

      m_addr  <= 8'h00;
      m_cen   <= 1'b1;
      m_wen   <= 1'b1;
      m_oen   <= 1'b1;
      m_ssn   <= 1'b1;
      m_dq_oe <= 1'b0;
      m_dq_o  <= 8'h00;
      case (nxt)
        S_UNLOCK: m_addr <= ADDR_NAK;
        S_W_SETUP, S_W_STROBE, S_W_HOLD: begin
          m_addr  <= waddr;
          m_dq_o  <= wbyte;
          m_dq_oe <= 1'b1;
          m_cen   <= 1'b0;
          m_wen   <= (nxt != S_W_STROBE);
        end
        S_R_READ: begin
          m_addr <= waddr;
          m_cen  <= 1'b0;
          m_oen  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
